// File: rtl/slv_mbox_pkg.sv
// slv_mbox_pkg: register map, STATUS/CTRL field positions and count saturation
// shared by the pcie_tlp slave mailbox.
package slv_mbox_pkg;

    localparam logic [2:0] REG_TXDATA = 3'd0;
    localparam logic [2:0] REG_RXDATA = 3'd1;
    localparam logic [2:0] REG_STATUS = 3'd2;
    localparam logic [2:0] REG_CTRL   = 3'd3;

    localparam int ST_H2F_OVF = 15;
    localparam int ST_F2H_OVF = 14;
    localparam int ST_F2H_CNT = 8;
    localparam int ST_H2F_CNT = 0;
    localparam int ST_CNT_W   = 5;

    localparam int CTRL_FLUSH_H2F = 0;
    localparam int CTRL_FLUSH_F2H = 1;
    localparam int CTRL_CLR_OVF   = 2;

    function automatic logic [ST_CNT_W-1:0] sat_cnt(input logic [8:0] c);
        return (c > 9'd31) ? 5'd31 : c[ST_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO with occupancy count and synchronous flush.
// A push is refused when full even if a pop happens on the same edge.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                   clk_125,
    input  logic                   rstn,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_cnt;
    logic             w_push;
    logic             w_pop;

    assign full   = r_cnt == CNT_FULL;
    assign empty  = r_cnt == '0;
    assign count  = r_cnt;
    assign w_push = push & ~full & ~flush;
    assign w_pop  = pop & ~empty & ~flush;
    assign dout   = empty ? '0 : r_mem[r_rd];

    always_ff @(posedge clk_125 or negedge rstn) begin
        if (!rstn) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else if (flush) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push)
                r_wr <= r_wr + AW'(1);
            if (w_pop)
                r_rd <= r_rd + AW'(1);
            r_cnt <= r_cnt + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
        end
    end

    always_ff @(posedge clk_125) begin
        if (w_push)
            r_mem[r_wr] <= din;
    end

endmodule

// File: rtl/slv_mbox_fifo.sv
// slv_mbox_fifo: host/FPGA mailbox on the pcie_tlp slave bus with an h2f and an
// f2h FIFO, sticky overflow flags and a registered read mux.
module slv_mbox_fifo
    import slv_mbox_pkg::*;
#(
    parameter int BAR_IDX = 3,
    parameter int DEPTH   = 16
) (
    input  logic        clk_125,
    input  logic        rstn,
    input  logic [6:0]  slv_bar_i,
    input  logic        slv_ce_i,
    input  logic        slv_we_i,
    input  logic [19:1] slv_adr_i,
    input  logic [15:0] slv_dat_i,
    input  logic [1:0]  slv_sel_i,
    output logic [15:0] slv_dat_o,
    output logic        h2f_valid,
    output logic [15:0] h2f_data,
    input  logic        h2f_ready,
    input  logic        f2h_valid,
    input  logic [15:0] f2h_data,
    output logic        f2h_ready
);

    logic                   w_acc;
    logic [2:0]             w_adr;
    logic                   w_tx_wr;
    logic                   w_rx_rd;
    logic                   w_ctrl_wr;
    logic                   w_flush_h2f;
    logic                   w_flush_f2h;
    logic                   w_clr_ovf;
    logic                   w_h2f_full;
    logic                   w_h2f_empty;
    logic                   w_f2h_full;
    logic                   w_f2h_empty;
    logic [$clog2(DEPTH):0] w_h2f_cnt;
    logic [$clog2(DEPTH):0] w_f2h_cnt;
    logic [15:0]            w_f2h_dout;
    logic [15:0]            w_status;
    logic [15:0]            w_rdata;
    logic                   w_unused;
    logic                   r_h2f_ovf;
    logic                   r_f2h_ovf;
    logic [15:0]            r_dat;

    assign w_acc       = slv_ce_i & slv_bar_i[BAR_IDX];
    assign w_adr       = slv_adr_i[3:1];
    assign w_tx_wr     = w_acc & slv_we_i & (w_adr == REG_TXDATA) & (slv_sel_i == 2'b11);
    assign w_rx_rd     = w_acc & ~slv_we_i & (w_adr == REG_RXDATA) & ~w_f2h_empty;
    assign w_ctrl_wr   = w_acc & slv_we_i & (w_adr == REG_CTRL) & slv_sel_i[0];
    assign w_flush_h2f = w_ctrl_wr & slv_dat_i[CTRL_FLUSH_H2F];
    assign w_flush_f2h = w_ctrl_wr & slv_dat_i[CTRL_FLUSH_F2H];
    assign w_clr_ovf   = w_ctrl_wr & slv_dat_i[CTRL_CLR_OVF];
    assign w_unused    = ^{slv_adr_i[19:4], slv_bar_i};

    assign h2f_valid = ~w_h2f_empty;
    assign f2h_ready = ~w_f2h_full;
    assign slv_dat_o = r_dat;

    sync_fifo #(.WIDTH(16), .DEPTH(DEPTH)) u_h2f (
        .clk_125 (clk_125),
        .rstn    (rstn),
        .push    (w_tx_wr),
        .pop     (h2f_ready),
        .flush   (w_flush_h2f),
        .din     (slv_dat_i),
        .dout    (h2f_data),
        .count   (w_h2f_cnt),
        .full    (w_h2f_full),
        .empty   (w_h2f_empty)
    );

    sync_fifo #(.WIDTH(16), .DEPTH(DEPTH)) u_f2h (
        .clk_125 (clk_125),
        .rstn    (rstn),
        .push    (f2h_valid),
        .pop     (w_rx_rd),
        .flush   (w_flush_f2h),
        .din     (f2h_data),
        .dout    (w_f2h_dout),
        .count   (w_f2h_cnt),
        .full    (w_f2h_full),
        .empty   (w_f2h_empty)
    );

    always_comb begin
        w_status = '0;
        w_status[ST_H2F_OVF] = r_h2f_ovf;
        w_status[ST_F2H_OVF] = r_f2h_ovf;
        w_status[ST_F2H_CNT +: ST_CNT_W] = sat_cnt(9'(w_f2h_cnt));
        w_status[ST_H2F_CNT +: ST_CNT_W] = sat_cnt(9'(w_h2f_cnt));
        w_rdata = (w_adr == REG_RXDATA) ? w_f2h_dout :
                  (w_adr == REG_STATUS) ? w_status : 16'h0000;
    end

    // A flush on the same edge suppresses the overflow it would otherwise record.
    always_ff @(posedge clk_125 or negedge rstn) begin
        if (!rstn) begin
            r_h2f_ovf <= 1'b0;
            r_f2h_ovf <= 1'b0;
            r_dat     <= 16'h0000;
        end else begin
            r_h2f_ovf <= (w_tx_wr & w_h2f_full & ~w_flush_h2f) | (r_h2f_ovf & ~w_clr_ovf);
            r_f2h_ovf <= (f2h_valid & w_f2h_full & ~w_flush_f2h) | (r_f2h_ovf & ~w_clr_ovf);
            if (w_acc & ~slv_we_i)
                r_dat <= w_rdata;
        end
    end

endmodule

// File: tb/tb_slv_mbox_fifo.sv
// tb_slv_mbox_fifo: directed scenarios plus a randomized run scored against a
// queue-based mailbox model.
module tb_slv_mbox_fifo;

    localparam int DEPTH = 16;

    logic        clk_125 = 1'b0;
    logic        rstn    = 1'b0;
    logic [6:0]  slv_bar_i;
    logic        slv_ce_i;
    logic        slv_we_i;
    logic [19:1] slv_adr_i;
    logic [15:0] slv_dat_i;
    logic [1:0]  slv_sel_i;
    logic [15:0] slv_dat_o;
    logic        h2f_valid;
    logic [15:0] h2f_data;
    logic        h2f_ready;
    logic        f2h_valid;
    logic [15:0] f2h_data;
    logic        f2h_ready;
    int          pass_cnt = 0;
    int          total    = 0;

    always #4 clk_125 = ~clk_125;

    slv_mbox_fifo #(.BAR_IDX(3), .DEPTH(DEPTH)) dut (
        .clk_125   (clk_125),
        .rstn      (rstn),
        .slv_bar_i (slv_bar_i),
        .slv_ce_i  (slv_ce_i),
        .slv_we_i  (slv_we_i),
        .slv_adr_i (slv_adr_i),
        .slv_dat_i (slv_dat_i),
        .slv_sel_i (slv_sel_i),
        .slv_dat_o (slv_dat_o),
        .h2f_valid (h2f_valid),
        .h2f_data  (h2f_data),
        .h2f_ready (h2f_ready),
        .f2h_valid (f2h_valid),
        .f2h_data  (f2h_data),
        .f2h_ready (f2h_ready)
    );

    task automatic idle();
        slv_ce_i  = 1'b0;
        slv_we_i  = 1'b0;
        slv_bar_i = 7'h08;
        slv_adr_i = '0;
        slv_dat_i = 16'h0000;
        slv_sel_i = 2'b11;
    endtask

    task automatic do_reset();
        idle();
        h2f_ready = 1'b0;
        f2h_valid = 1'b0;
        f2h_data  = 16'h0000;
        rstn      = 1'b0;
        repeat (2) @(posedge clk_125);
        #1 rstn = 1'b1;
    endtask

    task automatic access(input logic we, input logic [2:0] adr, input logic [15:0] dat,
                          input logic [1:0] sel, input logic [6:0] bar);
        slv_ce_i  = 1'b1;
        slv_we_i  = we;
        slv_adr_i = {16'h0000, adr};
        slv_dat_i = dat;
        slv_sel_i = sel;
        slv_bar_i = bar;
        @(posedge clk_125);
        #1 idle();
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (slv_dat_o !== 16'h0000) $display("FAIL reset_dat got %h exp 0000", slv_dat_o); else pass_cnt++;
        total++; if (h2f_valid !== 1'b0) $display("FAIL reset_h2f_valid got %b exp 0", h2f_valid); else pass_cnt++;
        total++; if (h2f_data !== 16'h0000) $display("FAIL reset_h2f_data got %h exp 0000", h2f_data); else pass_cnt++;
        total++; if (f2h_ready !== 1'b1) $display("FAIL reset_f2h_ready got %b exp 1", f2h_ready); else pass_cnt++;
        access(1'b0, 3'd2, 16'h0, 2'b11, 7'h08);
        total++; if (slv_dat_o !== 16'h0000) $display("FAIL reset_status got %h exp 0000", slv_dat_o); else pass_cnt++;
    endtask

    task automatic test_h2f();
        do_reset();
        access(1'b1, 3'd0, 16'h1234, 2'b11, 7'h08);
        access(1'b1, 3'd0, 16'hABCD, 2'b11, 7'h08);
        access(1'b0, 3'd2, 16'h0, 2'b11, 7'h08);
        total++; if (slv_dat_o !== 16'h0002) $display("FAIL h2f_status got %h exp 0002", slv_dat_o); else pass_cnt++;
        total++; if (h2f_data !== 16'h1234) $display("FAIL h2f_head got %h exp 1234", h2f_data); else pass_cnt++;
        h2f_ready = 1'b1;
        @(posedge clk_125); #1;
        total++; if (h2f_data !== 16'hABCD) $display("FAIL h2f_second got %h exp abcd", h2f_data); else pass_cnt++;
        @(posedge clk_125); #1;
        h2f_ready = 1'b0;
        total++; if (h2f_valid !== 1'b0) $display("FAIL h2f_drained got %b exp 0", h2f_valid); else pass_cnt++;
    endtask

    task automatic test_h2f_ovf();
        do_reset();
        for (int i = 0; i < 17; i++)
            access(1'b1, 3'd0, 16'h0100 + 16'(i), 2'b11, 7'h08);
        access(1'b0, 3'd2, 16'h0, 2'b11, 7'h08);
        total++; if (slv_dat_o !== 16'h8010) $display("FAIL h2f_ovf_status got %h exp 8010", slv_dat_o); else pass_cnt++;
        total++; if (h2f_data !== 16'h0100) $display("FAIL h2f_ovf_head got %h exp 0100", h2f_data); else pass_cnt++;
        access(1'b1, 3'd3, 16'h0004, 2'b11, 7'h08);
        access(1'b0, 3'd2, 16'h0, 2'b11, 7'h08);
        total++; if (slv_dat_o !== 16'h0010) $display("FAIL ovf_clear got %h exp 0010", slv_dat_o); else pass_cnt++;
        access(1'b1, 3'd3, 16'h0001, 2'b11, 7'h08);
        access(1'b0, 3'd2, 16'h0, 2'b11, 7'h08);
        total++; if (slv_dat_o !== 16'h0000) $display("FAIL h2f_flush got %h exp 0000", slv_dat_o); else pass_cnt++;
        total++; if (h2f_valid !== 1'b0) $display("FAIL h2f_flush_valid got %b exp 0", h2f_valid); else pass_cnt++;
    endtask

    task automatic test_f2h();
        do_reset();
        f2h_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            f2h_data = 16'(i + 1);
            @(posedge clk_125); #1;
        end
        total++; if (f2h_ready !== 1'b0) $display("FAIL f2h_full_ready got %b exp 0", f2h_ready); else pass_cnt++;
        f2h_data = 16'h0011;
        @(posedge clk_125); #1;
        f2h_valid = 1'b0;
        access(1'b0, 3'd2, 16'h0, 2'b11, 7'h08);
        total++; if (slv_dat_o !== 16'h5000) $display("FAIL f2h_ovf_status got %h exp 5000", slv_dat_o); else pass_cnt++;
        slv_ce_i  = 1'b1;
        slv_we_i  = 1'b0;
        slv_adr_i = {16'h0000, 3'd1};
        for (int i = 0; i < 16; i++) begin
            @(posedge clk_125); #1;
            total++; if (slv_dat_o !== 16'(i + 1)) $display("FAIL f2h_read%0d got %h exp %h", i, slv_dat_o, 16'(i + 1)); else pass_cnt++;
        end
        @(posedge clk_125); #1;
        idle();
        total++; if (slv_dat_o !== 16'h0000) $display("FAIL f2h_empty_read got %h exp 0000", slv_dat_o); else pass_cnt++;
        access(1'b0, 3'd2, 16'h0, 2'b11, 7'h08);
        total++; if (slv_dat_o !== 16'h4000) $display("FAIL f2h_after_status got %h exp 4000", slv_dat_o); else pass_cnt++;
    endtask

    task automatic test_ignored();
        do_reset();
        access(1'b1, 3'd0, 16'h5555, 2'b01, 7'h08);
        access(1'b1, 3'd0, 16'h6666, 2'b11, 7'h77);
        total++; if (h2f_valid !== 1'b0) $display("FAIL ignored_push got %b exp 0", h2f_valid); else pass_cnt++;
        access(1'b1, 3'd0, 16'h7777, 2'b11, 7'h08);
        access(1'b1, 3'd3, 16'h0001, 2'b10, 7'h08);
        access(1'b0, 3'd2, 16'h0, 2'b11, 7'h08);
        total++; if (slv_dat_o !== 16'h0001) $display("FAIL ignored_status got %h exp 0001", slv_dat_o); else pass_cnt++;
        access(1'b1, 3'd0, 16'h8888, 2'b11, 7'h08);
        total++; if (slv_dat_o !== 16'h0001) $display("FAIL read_hold got %h exp 0001", slv_dat_o); else pass_cnt++;
        access(1'b0, 3'd5, 16'h0, 2'b11, 7'h08);
        total++; if (slv_dat_o !== 16'h0000) $display("FAIL adr5_read got %h exp 0000", slv_dat_o); else pass_cnt++;
    endtask

    task automatic test_same_cycle();
        do_reset();
        f2h_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            f2h_data = 16'h00A0 + 16'(i);
            @(posedge clk_125); #1;
        end
        f2h_data  = 16'h00A3;
        slv_ce_i  = 1'b1;
        slv_we_i  = 1'b0;
        slv_adr_i = {16'h0000, 3'd1};
        @(posedge clk_125); #1;
        f2h_valid = 1'b0;
        idle();
        total++; if (slv_dat_o !== 16'h00A0) $display("FAIL same_cycle_data got %h exp 00a0", slv_dat_o); else pass_cnt++;
        access(1'b0, 3'd2, 16'h0, 2'b11, 7'h08);
        total++; if (slv_dat_o !== 16'h0300) $display("FAIL same_cycle_count got %h exp 0300", slv_dat_o); else pass_cnt++;
        for (int i = 1; i < 4; i++) begin
            access(1'b0, 3'd1, 16'h0, 2'b11, 7'h08);
            total++; if (slv_dat_o !== 16'h00A0 + 16'(i)) $display("FAIL same_cycle_rd%0d got %h exp %h", i, slv_dat_o, 16'h00A0 + 16'(i)); else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        f2h_valid = 1'b1;
        f2h_data  = 16'h0F0F;
        repeat (DEPTH) begin
            @(posedge clk_125); #1;
        end
        access(1'b1, 3'd0, 16'h2222, 2'b11, 7'h08);
        access(1'b1, 3'd0, 16'h3333, 2'b11, 7'h08);
        access(1'b0, 3'd2, 16'h0, 2'b11, 7'h08);
        total++; if (slv_dat_o !== 16'h5002) $display("FAIL pre_reset_status got %h exp 5002", slv_dat_o); else pass_cnt++;
        #2 rstn = 1'b0;
        #1;
        total++; if (slv_dat_o !== 16'h0000) $display("FAIL mid_reset_dat got %h exp 0000", slv_dat_o); else pass_cnt++;
        total++; if (h2f_valid !== 1'b0) $display("FAIL mid_reset_valid got %b exp 0", h2f_valid); else pass_cnt++;
        total++; if (h2f_data !== 16'h0000) $display("FAIL mid_reset_data got %h exp 0000", h2f_data); else pass_cnt++;
        total++; if (f2h_ready !== 1'b1) $display("FAIL mid_reset_ready got %b exp 1", f2h_ready); else pass_cnt++;
        f2h_valid = 1'b0;
        @(posedge clk_125);
        #1 rstn = 1'b1;
        access(1'b0, 3'd2, 16'h0, 2'b11, 7'h08);
        total++; if (slv_dat_o !== 16'h0000) $display("FAIL post_reset_status got %h exp 0000", slv_dat_o); else pass_cnt++;
    endtask

    task automatic test_random();
        logic [15:0] hq[$];
        logic [15:0] fq[$];
        logic        hov;
        logic        fov;
        logic [15:0] exp_dat;
        logic [15:0] dat;
        logic [6:0]  bar;
        logic [2:0]  adr;
        logic [1:0]  sel;
        logic        we;
        logic        ce;
        logic        acc;
        logic        tx;
        logic        rx;
        logic        ctl;
        logic        hfull;
        logic        ffull;
        int          kind;
        do_reset();
        hov     = 1'b0;
        fov     = 1'b0;
        exp_dat = 16'h0000;
        for (int n = 0; n < 800; n++) begin
            kind = $urandom_range(0, 9);
            ce   = $urandom_range(0, 2) != 0;
            bar  = 7'($urandom);
            bar[3] = $urandom_range(0, 9) != 0;
            dat  = 16'($urandom);
            sel  = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b11;
            we   = 1'b0;
            adr  = 3'd0;
            if (kind <= 3) begin we = 1'b1; adr = 3'd0; end
            else if (kind <= 5) adr = 3'd1;
            else if (kind == 6) adr = 3'd2;
            else if (kind == 7) begin
                we  = 1'b1;
                adr = 3'd3;
                dat = ($urandom_range(0, 15) == 0) ? 16'($urandom_range(0, 7)) : 16'h0000;
            end else if (kind == 8) begin
                we  = 1'($urandom);
                adr = 3'($urandom_range(4, 7));
            end else adr = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'd3;
            slv_ce_i  = ce;
            slv_we_i  = we;
            slv_bar_i = bar;
            slv_adr_i = {16'($urandom), adr};
            slv_dat_i = dat;
            slv_sel_i = sel;
            h2f_ready = (n < 400) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0);
            f2h_valid = (n < 400) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 7) == 0);
            f2h_data  = 16'($urandom);
            @(posedge clk_125); #1;
            acc   = ce && bar[3];
            tx    = acc && we && adr == 3'd0 && sel == 2'b11;
            rx    = acc && !we && adr == 3'd1;
            ctl   = acc && we && adr == 3'd3 && sel[0];
            hfull = hq.size() >= DEPTH;
            ffull = fq.size() >= DEPTH;
            if (acc && !we)
                exp_dat = (adr == 3'd1) ? ((fq.size() > 0) ? fq[0] : 16'h0000) :
                          (adr == 3'd2) ? {hov, fov, 1'b0, (fq.size() > 31) ? 5'd31 : 5'(fq.size()),
                                           3'b000, (hq.size() > 31) ? 5'd31 : 5'(hq.size())} : 16'h0000;
            hov = (tx && hfull && !(ctl && dat[0])) || (hov && !(ctl && dat[2]));
            fov = (f2h_valid && ffull && !(ctl && dat[1])) || (fov && !(ctl && dat[2]));
            if (ctl && dat[0]) hq.delete();
            else begin
                if (h2f_ready && hq.size() > 0) void'(hq.pop_front());
                if (tx && !hfull) hq.push_back(dat);
            end
            if (ctl && dat[1]) fq.delete();
            else begin
                if (rx && fq.size() > 0) void'(fq.pop_front());
                if (f2h_valid && !ffull) fq.push_back(f2h_data);
            end
            total++; if (slv_dat_o !== exp_dat) $display("FAIL rnd_dat cyc %0d got %h exp %h", n, slv_dat_o, exp_dat); else pass_cnt++;
            total++; if (h2f_valid !== (hq.size() > 0)) $display("FAIL rnd_h2f_valid cyc %0d got %b exp %b", n, h2f_valid, hq.size() > 0); else pass_cnt++;
            total++; if (h2f_data !== ((hq.size() > 0) ? hq[0] : 16'h0000)) $display("FAIL rnd_h2f_data cyc %0d got %h exp %h", n, h2f_data, (hq.size() > 0) ? hq[0] : 16'h0000); else pass_cnt++;
            total++; if (f2h_ready !== (fq.size() < DEPTH)) $display("FAIL rnd_f2h_ready cyc %0d got %b exp %b", n, f2h_ready, fq.size() < DEPTH); else pass_cnt++;
        end
        idle();
        h2f_ready = 1'b0;
        f2h_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_h2f();
        test_h2f_ovf();
        test_f2h();
        test_ignored();
        test_same_cycle();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/slv_mbox_fifo.md
# slv_mbox_fifo

Host/FPGA mailbox on the pcie_tlp slave bus. It occupies one BAR and holds two 16-bit FIFOs:
- h2f: host writes are delivered to user logic as a ready/valid stream.
- f2h: a user-logic stream is read by the host, with status and sticky error flags.

It sits beside the BAR0 LED register and the BAR1/BAR2 RAMs. Its registered read data is OR-merged into slv_dat_o under its BAR bit.

## Interface
Parameters:
- BAR_IDX, 3: slv_bar_i bit that selects this block.
- DEPTH, 16: entries per FIFO; must be a power of two, 2 to 256.

Ports:
- clk_125  in  1  125 MHz core clock.
- rstn  in  1  asynchronous, active-low reset.
- slv_bar_i  in  7  BAR hit vector.
- slv_ce_i  in  1  access strobe; one access per asserted cycle.
- slv_we_i  in  1  1 = write, 0 = read.
- slv_adr_i  in  19  word address [19:1]; only [3:1] are decoded.
- slv_dat_i  in  16  write data.
- slv_sel_i  in  2  byte enables.
- slv_dat_o  out  16  registered read data.
- h2f_valid  out  1  h2f head valid (first-word fall-through).
- h2f_data  out  16  h2f head word.
- h2f_ready  in  1  user pops h2f.
- f2h_valid  in  1  user pushes f2h.
- f2h_data  in  16  word to push.
- f2h_ready  out  1  f2h not full.

## Operation
- An access is a cycle with slv_ce_i=1 and slv_bar_i[BAR_IDX]=1.
- Register map, slv_adr_i[3:1]:
  - 0 TXDATA: write with sel=2'b11 pushes slv_dat_i to h2f. A write with any other sel is ignored. Reads return 0.
  - 1 RXDATA: read returns the f2h head and pops it. Reading an empty f2h returns 0 and pops nothing.
  - 2 STATUS (read-only): [15] h2f_ovf, [14] f2h_ovf, [13] 0, [12:8] f2h count (saturates at 31), [7:5] 0, [4:0] h2f count (saturates at 31).
  - 3 CTRL: write bit0 flushes h2f; bit1 flushes f2h; bit2 clears both ovf flags. Reads return 0. sel[0] must be 1, else the write is ignored.
  - 4–7: reads return 0; writes are ignored.
- h2f push is accepted only if the h2f count is below DEPTH before the edge. A same-cycle pop does not free a slot. A rejected push sets h2f_ovf.
- f2h push occurs when f2h_valid & f2h_ready. f2h_ready = count < DEPTH. f2h_valid while f2h_ready=0 sets f2h_ovf; the word is dropped.
- Pop and push on the same FIFO in one cycle are both performed, and the count is unchanged.
- Flush vs. push/pop on the same FIFO in one cycle: flush wins and the push/pop is discarded; the ovf flag is not set by it.
- Flag clear vs. a new overflow in one cycle: set wins.
- Pointers are log2(DEPTH) bits and wrap naturally. The count is log2(DEPTH)+1 bits.

## Timing
- Reset values: slv_dat_o=0, h2f_valid=0, h2f_data=0, f2h_ready=1, both FIFOs empty, both ovf flags=0.
- Read latency is 1: slv_dat_o updates on the edge after the access. It holds its value on non-read cycles.
- An RXDATA pop takes effect on that same edge, so back-to-back RXDATA reads return consecutive entries.
- STATUS read on the same cycle as a push or pop reflects counts before the edge.
- h2f visibility: a TXDATA write at edge N gives h2f_valid=1 and h2f_data valid after edge N.
- f2h visibility: an f2h push at edge N is readable by an RXDATA access in cycle N+1 or later.
- Reset asserted mid-operation clears everything asynchronously. Stored contents are not required to be cleared.

## Structure
- Shared package slv_mbox_pkg:
  - register offsets REG_TXDATA=0, REG_RXDATA=1, REG_STATUS=2, REG_CTRL=3;
  - STATUS bit positions;
  - CTRL bit positions.
- Sub-module sync_fifo, instantiated twice (h2f, f2h):
  - parameters WIDTH and DEPTH;
  - ports push, pop, flush, din, dout (FWFT), count, full, empty.
- The top level holds only the decode, ovf flags and the read mux.

## Test plan
- Reset, then read STATUS -> 0x0000; f2h_ready=1; h2f_valid=0.
- Write 0x1234 then 0xABCD to TXDATA; hold h2f_ready=0 -> STATUS[4:0]=2, h2f_data=0x1234; pulse h2f_ready for 2 cycles -> 0xABCD, then h2f_valid=0.
- Perform 17 TXDATA writes with DEPTH=16 -> count 16, STATUS=0x8010; write CTRL=0x0004 -> 0x0010; write CTRL=0x0001 -> 0x0000.
- Push f2h 0x0001..0x0010; a 17th push with f2h_ready=0 -> f2h_ovf; 16 back-to-back RXDATA reads -> 0x0001..0x0010 in order; 17th read -> 0x0000.
- Write with sel=2'b01 to TXDATA, or with slv_bar_i[BAR_IDX]=0 -> no push; read of address 5 -> 0.
- Same-cycle f2h push and RXDATA pop at count 3 -> count stays 3; deassert rstn mid-burst -> all outputs at reset values.
